// File: rtl/adder_pkg.sv
// Shared constants and types for the sliced carry-lookahead adder.
package adder_pkg;

    localparam int ADDER_SLICE_W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int adder_slice_count(input int width);
        return width / ADDER_SLICE_W;
    endfunction

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice: local sum, carry-out and group generate/propagate.
module adder_cla4
    import adder_pkg::*;
(
    input  logic [ADDER_SLICE_W-1:0] a,
    input  logic [ADDER_SLICE_W-1:0] b,
    input  logic                     cin,
    output logic [ADDER_SLICE_W-1:0] sum,
    output logic                     cout,
    output gp_t                      gp
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every internal carry is a flat sum of products of cin, so no carry ripples inside the slice.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp.p = &p;

    assign sum  = p ^ c;
    assign cout = gp.g | (gp.p & cin);

endmodule

// File: rtl/sixty_four_bit_adder.sv
// WIDTH-bit adder built from 4-bit lookahead slices, with a registered copy of the result.
// Optional signed-overflow outputs ovf/ovf_q are enabled by ADDER_SIGNED_OVERFLOW_EN.
module sixty_four_bit_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             c_out_q
`ifdef ADDER_SIGNED_OVERFLOW_EN
    ,
    output logic             ovf,
    output logic             ovf_q
`endif
);

    localparam int NSLICE = adder_slice_count(WIDTH);

    logic [NSLICE:0]   carry;
    gp_t  [NSLICE-1:0] slice_gp;

    assign carry[0] = c_in;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        adder_cla4 u_cla4 (
            .a    (a[i*ADDER_SLICE_W +: ADDER_SLICE_W]),
            .b    (b[i*ADDER_SLICE_W +: ADDER_SLICE_W]),
            .cin  (carry[i]),
            .sum  (sum[i*ADDER_SLICE_W +: ADDER_SLICE_W]),
            .cout (carry[i+1]),
            .gp   (slice_gp[i])
        );
    end

    assign c_out = carry[NSLICE];

    // Group terms are there for a second lookahead level; a chain of slices only needs cout.
    logic unused_gp;
    assign unused_gp = ^slice_gp;

`ifdef ADDER_SIGNED_OVERFLOW_EN
    logic msb_carry_in;

    // Carry into the MSB is recovered from the MSB sum bit, since it sits inside the top slice.
    assign msb_carry_in = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];
    assign ovf          = msb_carry_in ^ c_out;

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf;
    end
`endif

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum;
            c_out_q <= c_out;
        end
    end

endmodule

// File: tb/tb_sixty_four_bit_adder.sv
// Self-checking bench for sixty_four_bit_adder: combinational result plus scoreboarded registered copy.
module tb_sixty_four_bit_adder;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] sum;
    logic         c_out;
    logic [W-1:0] sum_q;
    logic         c_out_q;
`ifdef ADDER_SIGNED_OVERFLOW_EN
    logic         ovf;
    logic         ovf_q;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    sixty_four_bit_adder #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .sum     (sum),
        .c_out   (c_out),
        .sum_q   (sum_q),
        .c_out_q (c_out_q)
`ifdef ADDER_SIGNED_OVERFLOW_EN
        ,
        .ovf     (ovf),
        .ovf_q   (ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s differs", tag);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t        e;
        logic [W:0]  full;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    // Drive one operand set, check the combinational result, queue it, then check the registered copy.
    task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t e;
        exp_t r;
        @(negedge clk);
        a    = x;
        b    = y;
        c_in = ci;
        #1;
        e = model(x, y, ci);
        check({tag, ".sum"},   sum,   e.sum);
        check({tag, ".c_out"}, {63'd0, c_out}, {63'd0, e.cout});
`ifdef ADDER_SIGNED_OVERFLOW_EN
        check({tag, ".ovf"},   {63'd0, ovf},   {63'd0, e.ovf});
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        r = sb.pop_front();
        check({tag, ".sum_q"},   sum_q,              r.sum);
        check({tag, ".c_out_q"}, {63'd0, c_out_q},   {63'd0, r.cout});
`ifdef ADDER_SIGNED_OVERFLOW_EN
        check({tag, ".ovf_q"},   {63'd0, ovf_q},     {63'd0, r.ovf});
`endif
    endtask

    initial begin
        reset = 1'b1;
        a     = 64'd5;
        b     = 64'd7;
        c_in  = 1'b1;

        // Reset held for two edges: combinational path still live, registers cleared.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.sum",     sum,              64'd13);
        check("rst.c_out",   {63'd0, c_out},   64'd0);
        check("rst.sum_q",   sum_q,            64'd0);
        check("rst.c_out_q", {63'd0, c_out_q}, 64'd0);
`ifdef ADDER_SIGNED_OVERFLOW_EN
        check("rst.ovf_q",   {63'd0, ovf_q},   64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rel.sum_q",   sum_q,            64'd13);
        check("rel.c_out_q", {63'd0, c_out_q}, 64'd0);

        step("ripple",  64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1'b1);
        step("mid",     64'h0000_0000_FFFF_FFFF, 64'd1,                  1'b0);
        step("max",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step("zero",    64'd0,                   64'd0,                  1'b0);
        step("i5",      64'd10,                  64'(5) << 30,           1'b0);
        step("smax",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0);
        step("smin",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        step("neg1",    64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0);
        step("nib",     64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);

        // Mid-stream reset clears the registers for one edge only.
        @(negedge clk);
        reset = 1'b1;
        a     = 64'h1234;
        b     = 64'h1;
        c_in  = 1'b0;
        @(posedge clk);
        #1;
        check("mrst.sum_q",   sum_q,            64'd0);
        check("mrst.c_out_q", {63'd0, c_out_q}, 64'd0);
        check("mrst.sum",     sum,              64'h1235);
        @(negedge clk);
        reset = 1'b0;
        step("resume",  64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 1'b0);

        for (int i = 0; i < 32767; i++) begin
            step("sweep", 64'(2 * i), 64'(i) << 30, 1'b0);
        end

        check("sb.empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
